// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I-lite pipeline: datapath width and ALU opcodes.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_EQ   = 4'b1010,
    ALU_LE   = 4'b1011,
    ALU_NE   = 4'b1100,
    ALU_GE   = 4'b1101,
    ALU_GEU  = 4'b1110,
    ALU_LUI  = 4'b1111
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU for the EX stage; compare ops yield 0/1 zero-extended.
module alu
  import riscv_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] res
);

  localparam int SHW = $clog2(N);

  alu_op_t               op_e;
  logic signed [N-1:0]   a_s;
  logic signed [N-1:0]   b_s;
  logic        [SHW-1:0] shamt;

  assign op_e  = alu_op_t'(op);
  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    res = '0;
    case (op_e)
      ALU_AND:  res = a & b;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $unsigned(a_s >>> shamt);
      ALU_SLT:  res = {{(N-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res = {{(N-1){1'b0}}, (a < b)};
      ALU_EQ:   res = {{(N-1){1'b0}}, (a == b)};
      ALU_LE:   res = {{(N-1){1'b0}}, (a_s <= b_s)};
      ALU_NE:   res = {{(N-1){1'b0}}, (a != b)};
      ALU_GE:   res = {{(N-1){1'b0}}, (a_s >= b_s)};
      ALU_GEU:  res = {{(N-1){1'b0}}, (a >= b)};
      ALU_LUI:  res = b;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// EX stage: operand-2 select, ALU, branch-target adder and the EX/MEM register.
module execute
  import riscv_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regEn,
  input  logic [N-1:0] NPCin,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] Imm,
  input  logic         muxSel,
  input  logic [3:0]   aluControl,
  output logic [N-1:0] NPCbranch,
  output logic [N-1:0] ALUres,
  output logic [N-1:0] Bout,
  output logic         zero
);

  logic [N-1:0] op2;
  logic [N-1:0] tgt;
  logic [N-1:0] alu_res;

  logic [N-1:0] npc_branch_d, npc_branch_q;
  logic [N-1:0] alu_res_d,    alu_res_q;
  logic [N-1:0] b_d,          b_q;
  logic         zero_d,       zero_q;

  assign op2 = muxSel ? Imm : B;
  // Immediate is in halfword units; the carry out of the adder is dropped.
  assign tgt = NPCin + (Imm << 1);

  alu #(.N(N)) u_alu (
    .a   (A),
    .b   (op2),
    .op  (aluControl),
    .res (alu_res)
  );

  always_comb begin
    npc_branch_d = npc_branch_q;
    alu_res_d    = alu_res_q;
    b_d          = b_q;
    zero_d       = zero_q;
    if (regEn) begin
      npc_branch_d = tgt;
      alu_res_d    = alu_res;
      b_d          = B;
      zero_d       = (alu_res == '0);
    end
  end

  // EX/MEM boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      npc_branch_q <= '0;
      alu_res_q    <= '0;
      b_q          <= '0;
      zero_q       <= 1'b0;
    end else begin
      npc_branch_q <= npc_branch_d;
      alu_res_q    <= alu_res_d;
      b_q          <= b_d;
      zero_q       <= zero_d;
    end
  end

  assign NPCbranch = npc_branch_q;
  assign ALUres    = alu_res_q;
  assign Bout      = b_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage: behavioural model checked every cycle plus literal checks.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regEn = 1'b0;
  logic [31:0] NPCin = '0, A = '0, B = '0, Imm = '0;
  logic        muxSel = 1'b0;
  logic [3:0]  aluControl = '0;
  logic [31:0] NPCbranch, ALUres, Bout;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_npc = '0, m_alu = '0, m_b = '0;
  logic        m_zero = 1'b0;

  execute dut (
    .clk(clk), .rst(rst), .regEn(regEn), .NPCin(NPCin), .A(A), .B(B), .Imm(Imm),
    .muxSel(muxSel), .aluControl(aluControl),
    .NPCbranch(NPCbranch), .ALUres(ALUres), .Bout(Bout), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input int op);
    int sh;
    sh = int'(y[4:0]);
    case (op)
      0:  return x & y;
      1:  return x + y;
      2:  return x - y;
      3:  return x | y;
      4:  return x ^ y;
      5:  return x << sh;
      6:  return x >> sh;
      7:  return $signed(x) >>> sh;
      8:  return ($signed(x) <  $signed(y)) ? 32'd1 : 32'd0;
      9:  return (x < y)                    ? 32'd1 : 32'd0;
      10: return (x == y)                   ? 32'd1 : 32'd0;
      11: return ($signed(x) <= $signed(y)) ? 32'd1 : 32'd0;
      12: return (x != y)                   ? 32'd1 : 32'd0;
      13: return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
      14: return (x >= y)                   ? 32'd1 : 32'd0;
      default: return y;
    endcase
  endfunction

  // Model of the EX/MEM register contents
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_npc = '0; m_alu = '0; m_b = '0; m_zero = 1'b0;
    end else if (regEn) begin
      m_alu  = ref_alu(A, muxSel ? Imm : B, int'(aluControl));
      m_npc  = NPCin + 2 * Imm;
      m_b    = B;
      m_zero = (m_alu == 32'd0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_npcbranch", NPCbranch, m_npc);
      check("model_alures",    ALUres,    m_alu);
      check("model_bout",      Bout,      m_b);
      check("model_zero",      {31'd0, zero}, {31'd0, m_zero});
    end
  end

  task automatic drive(input logic [31:0] npc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic sel, input logic [3:0] op, input logic en);
    NPCin = npc; A = a; B = b; Imm = imm; muxSel = sel; aluControl = op; regEn = en;
  endtask

  // Advance one capture edge, then land on the following negedge with the bench's compare done.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [31:0] pa [5];
  logic [31:0] pb [5];

  initial begin
    pa[0] = 32'd5;          pb[0] = 32'd3;
    pa[1] = 32'd3;          pb[1] = 32'd5;
    pa[2] = 32'h8000_0000;  pb[2] = 32'd1;
    pa[3] = 32'hffff_ffff;  pb[3] = 32'hffff_ffff;
    pa[4] = 32'h1234_5678;  pb[4] = 32'h0000_001f;

    #1 rst = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, 1'b1, 4'h1, 1'b1);
    @(negedge clk);
    cmp_en = 1'b1;
    step();
    check("rst_npcbranch", NPCbranch, 32'd0);
    check("rst_alures",    ALUres,    32'd0);
    check("rst_bout",      Bout,      32'd0);
    check("rst_zero",      {31'd0, zero}, 32'd0);
    rst = 1'b1;

    drive(32'h0040_0004, 32'h0001_fc18, 32'h0, 32'h10, 1'b1, 4'b0001, 1'b1);
    step();
    check("addi_alures", ALUres,    32'h0001_fc28);
    check("addi_zero",   {31'd0, zero}, 32'd0);
    check("addi_npc",    NPCbranch, 32'h0040_0024);

    drive(32'h0, 32'h21d, 32'h266, 32'h0, 1'b0, 4'b0010, 1'b1);
    step();
    check("sub_alures", ALUres, 32'hffff_ffb7);
    check("sub_bout",   Bout,   32'h266);
    check("sub_zero",   {31'd0, zero}, 32'd0);

    drive(32'h0040_00b4, 32'h21d, 32'h266, 32'd4, 1'b0, 4'b1011, 1'b1);
    step();
    check("ble_t_alures", ALUres,    32'd1);
    check("ble_t_npc",    NPCbranch, 32'h0040_00bc);
    drive(32'h0040_00b4, 32'h266, 32'h21d, 32'd4, 1'b0, 4'b1011, 1'b1);
    step();
    check("ble_nt_alures", ALUres, 32'd0);
    check("ble_nt_zero",   {31'd0, zero}, 32'd1);

    drive(32'h1000, 32'd7, 32'd8, 32'd2, 1'b0, 4'b0001, 1'b0);
    step();
    step();
    check("stall_alures", ALUres,    32'd0);
    check("stall_npc",    NPCbranch, 32'h0040_00bc);
    check("stall_bout",   Bout,      32'h21d);
    regEn = 1'b1;
    step();
    check("resume_alures", ALUres,    32'd15);
    check("resume_npc",    NPCbranch, 32'h1004);

    drive(32'h0, 32'h8000_0000, 32'd31, 32'h0, 1'b0, 4'b0111, 1'b1);
    step();
    check("sra_edge", ALUres, 32'hffff_ffff);
    drive(32'h0, 32'hffff_ffff, 32'h0, 32'd1, 1'b1, 4'b1000, 1'b1);
    step();
    check("slt_edge", ALUres, 32'd1);
    aluControl = 4'b1001;
    step();
    check("sltu_edge", ALUres, 32'd0);
    drive(32'h0, 32'hffff_ffff, 32'd1, 32'h0, 1'b0, 4'b0001, 1'b1);
    step();
    check("add_wrap_alures", ALUres, 32'd0);
    check("add_wrap_zero",   {31'd0, zero}, 32'd1);
    drive(32'hffff_fff0, 32'h0, 32'h0, 32'h10, 1'b1, 4'b1111, 1'b1);
    step();
    check("lui_pass",   ALUres,    32'h10);
    check("npc_wrap",   NPCbranch, 32'h10);

    for (int p = 0; p < 5; p++) begin
      for (int op = 0; op < 16; op++) begin
        drive(32'h0040_0000 + 32'(op * 4), pa[p], pb[p], ~pb[p] ^ 32'(p), (op % 3) == 0, 4'(op), 1'b1);
        step();
      end
    end

    // Asynchronous reset mid-cycle drops the captured result immediately.
    drive(32'h200, 32'd9, 32'd4, 32'd1, 1'b0, 4'b0001, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_alures", ALUres,    32'd0);
    check("midrst_npc",    NPCbranch, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    step();
    check("post_rst_alures", ALUres, 32'd13);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
